// File: rtl/lap_pkg.sv
// Shared types and constants for the sequence datapath.
// Holds the base codes, the packed-word geometry and the packer FSM states.
package lap_pkg;

  localparam int BASE_W         = 2;
  localparam int WORD_W         = 32;
  localparam int BASES_PER_WORD = WORD_W / BASE_W;
  localparam int CNT_W          = 5;

  typedef enum logic [BASE_W-1:0] {
    A = 2'd0,
    C = 2'd1,
    G = 2'd2,
    T = 2'd3
  } base_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pk_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [CNT_W-1:0]  count;
    logic              last;
  } word_t;

  // A base moved into its slot of an otherwise zero word.
  function automatic logic [WORD_W-1:0] place_base(input logic [BASE_W-1:0] b,
                                                   input logic [CNT_W-1:0]  slot);
    return WORD_W'(b) << {slot[3:0], 1'b0};
  endfunction

endpackage

// File: rtl/seq_packer_obuf.sv
// Output holding register of the packer plus its valid/ready stall terms.
// SEQ_PACKER_PARITY_EN adds a registered XOR parity of the held word.
module seq_packer_obuf
  import lap_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              load,
  input  logic              word_ready,
  input  logic [WORD_W-1:0] ld_data,
  input  logic [CNT_W-1:0]  ld_count,
  input  logic              ld_last,
  output logic              base_ready,
  output logic              word_xfer,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data,
  output logic [CNT_W-1:0]  word_count,
  output logic              word_last
`ifdef SEQ_PACKER_PARITY_EN
  ,
  output logic              word_parity
`endif
);

  word_t wreg;

  // A full buffer can still take a base if it empties in the same cycle.
  assign base_ready = !hold || word_ready;
  assign word_xfer  = hold && word_ready;
  assign word_valid = hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wreg <= '0;
    end else if (load) begin
      wreg <= '{data: ld_data, count: ld_count, last: ld_last};
    end
  end

  assign word_data  = wreg.data;
  assign word_count = wreg.count;
  assign word_last  = wreg.last;

`ifdef SEQ_PACKER_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    word_parity <= 1'b0;
    else if (load) word_parity <= ^ld_data;
  end
`endif

endmodule

// File: rtl/seq_packer.sv
// Packs 2-bit base codes LSB-first into 32-bit words; base_last flushes a
// zero-padded partial word. Optional parity output: SEQ_PACKER_PARITY_EN.
module seq_packer
  import lap_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              base_valid,
  output logic              base_ready,
  input  logic [BASE_W-1:0] base_data,
  input  logic              base_last,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [WORD_W-1:0] word_data,
  output logic [4:0]        word_count,
  output logic              word_last
`ifdef SEQ_PACKER_PARITY_EN
  ,
  output logic              word_parity
`endif
);

  pk_state_t         state, state_nxt;
  logic [WORD_W-1:0] acc;
  logic [CNT_W-1:0]  fill_cnt;
  logic              base_xfer, word_xfer, complete;
  logic [WORD_W-1:0] new_word;

  assign base_xfer = base_valid && base_ready;
  assign complete  = base_xfer && (base_last || fill_cnt == CNT_W'(BASES_PER_WORD - 1));
  // acc is cleared on every completion, so slots above fill_cnt are already zero.
  assign new_word  = acc | place_base(base_data, fill_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      fill_cnt <= '0;
    end else if (complete) begin
      acc      <= '0;
      fill_cnt <= '0;
    end else if (base_xfer) begin
      acc      <= new_word;
      fill_cnt <= fill_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (complete) state_nxt = HOLD;
      HOLD: begin
        if (complete)       state_nxt = HOLD;
        else if (word_xfer) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  seq_packer_obuf u_obuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold       (state == HOLD),
    .load       (complete),
    .word_ready (word_ready),
    .ld_data    (new_word),
    .ld_count   (fill_cnt + 1'b1),
    .ld_last    (base_last),
    .base_ready (base_ready),
    .word_xfer  (word_xfer),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_count (word_count),
    .word_last  (word_last)
`ifdef SEQ_PACKER_PARITY_EN
    ,
    .word_parity(word_parity)
`endif
  );

endmodule
